// File: rtl/axi_mm_patgen_pkg.sv
// rtl/axi_mm_patgen_pkg.sv - shared encodings and default constants for the pattern generator
package axi_mm_patgen_pkg;

  typedef enum logic [1:0] {
    PAT_FIXED = 2'b00,
    PAT_PRBS  = 2'b01,
    PAT_INCR  = 2'b10,
    PAT_WALK  = 2'b11
  } pat_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GEN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } run_state_e;

  localparam logic [39:0] DEF_FIXED_PAT = 40'h33_3333_3344;
  localparam logic [39:0] DEF_PRBS_SEED = 40'hAA_5555_9001;
  localparam logic [39:0] DEF_PRBS_TAPS = 40'hA0_0014_0000;
  localparam logic [39:0] DEF_INCR_SEED = 40'h44_4444_4444;

endpackage

// File: rtl/patgen_sync_fifo.sv
// rtl/patgen_sync_fifo.sv - single-clock first-word fall-through FIFO
module patgen_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/axi_mm_patgen_mc.sv
// rtl/axi_mm_patgen_mc.sv - multi-lane pattern generator with run FSM, FIFO and expected-data mirror
module axi_mm_patgen_mc
  import axi_mm_patgen_pkg::*;
#(
  parameter int                DWIDTH     = 40,
  parameter int                NUM_CHNL   = 7,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [DWIDTH-1:0] FIXED_PAT  = DWIDTH'(DEF_FIXED_PAT),
  parameter logic [DWIDTH-1:0] PRBS_SEED  = DWIDTH'(DEF_PRBS_SEED),
  parameter logic [DWIDTH-1:0] PRBS_TAPS  = DWIDTH'(DEF_PRBS_TAPS),
  parameter logic [DWIDTH-1:0] INCR_SEED  = DWIDTH'(DEF_INCR_SEED)
) (
  input  logic                         wr_clk,
  input  logic                         rst,
  input  logic                         patgen_en,
  input  logic [1:0]                   patgen_sel,
  input  logic                         cntuspatt_en,
  input  logic [7:0]                   patgen_cnt,
  input  logic                         patgen_stop,
  input  logic                         chkr_fifo_full,
  output logic                         axist_valid,
  input  logic                         axist_rdy,
  output logic [NUM_CHNL*DWIDTH-1:0]   patgen_dout,
  output logic [DWIDTH-1:0]            patgen_exp_dout,
  output logic                         patgen_data_wr,
  output logic                         patgen_busy,
  output logic                         patgen_done,
  output logic [15:0]                  beat_cnt
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [DWIDTH-1:0] PRBS_INIT =
    (PRBS_SEED == '0) ? {{(DWIDTH-1){1'b0}}, 1'b1} : PRBS_SEED;
  localparam logic [DWIDTH-1:0] WALK_INIT = {{(DWIDTH-1){1'b0}}, 1'b1};

  run_state_e  state;
  run_state_e  state_nxt;
  pat_sel_e    sel_q;
  logic        cont_q;
  logic [7:0]  remaining;
  logic        en_d;
  logic        start;
  logic        wr;
  logic        pop;

  logic [DWIDTH-1:0] prbs_q;
  logic [DWIDTH-1:0] incr_q;
  logic [DWIDTH-1:0] walk_q;
  logic [DWIDTH-1:0] gen_word;
  logic [DWIDTH-1:0] fifo_dout;
  logic [DWIDTH-1:0] lane_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign start = patgen_en & ~en_d;
  assign wr    = (state == GEN) & ~fifo_full & ~chkr_fifo_full & (cont_q | (remaining != 8'd0));
  assign pop   = axist_valid & axist_rdy;

  assign axist_valid     = ~fifo_empty;
  assign lane_word       = axist_valid ? fifo_dout : '0;
  assign patgen_dout     = {NUM_CHNL{lane_word}};
  assign patgen_data_wr  = wr;
  assign patgen_exp_dout = wr ? gen_word : '0;
  assign patgen_busy     = (state != IDLE);
  assign patgen_done     = (state == DONE);

  always_comb begin
    gen_word = FIXED_PAT;
    case (sel_q)
      PAT_PRBS: gen_word = prbs_q;
      PAT_INCR: gen_word = incr_q;
      PAT_WALK: gen_word = walk_q;
      default:  gen_word = FIXED_PAT;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = GEN;
      GEN:   if ((!cont_q && remaining == 8'd0) || (cont_q && patgen_stop)) state_nxt = DRAIN;
      DRAIN: if (fifo_count == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state     <= IDLE;
      en_d      <= 1'b0;
      sel_q     <= PAT_FIXED;
      cont_q    <= 1'b0;
      remaining <= 8'd0;
      prbs_q    <= PRBS_INIT;
      incr_q    <= INCR_SEED;
      walk_q    <= WALK_INIT;
      beat_cnt  <= 16'd0;
    end else begin
      state <= state_nxt;
      en_d  <= patgen_en;
      if (state == IDLE && start) begin
        sel_q     <= pat_sel_e'(patgen_sel);
        cont_q    <= cntuspatt_en;
        remaining <= patgen_cnt;
        prbs_q    <= PRBS_INIT;
        incr_q    <= INCR_SEED;
        walk_q    <= WALK_INIT;
        beat_cnt  <= 16'd0;
      end else begin
        // All generators step together; only the selected one is observed
        if (wr) begin
          prbs_q <= {prbs_q[DWIDTH-2:0], ^(prbs_q & PRBS_TAPS)};
          incr_q <= incr_q + 1'b1;
          walk_q <= {walk_q[DWIDTH-2:0], walk_q[DWIDTH-1]};
          if (!cont_q) remaining <= remaining - 8'd1;
        end
        if (pop && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

  patgen_sync_fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wr_clk),
    .rst   (rst),
    .push  (wr),
    .din   (gen_word),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_axi_mm_patgen_mc.sv
// tb/tb_axi_mm_patgen_mc.sv - self-checking bench for axi_mm_patgen_mc
module tb_axi_mm_patgen_mc;

  localparam int DW = 40;
  localparam int NC = 7;

  logic              wr_clk = 1'b0;
  logic              rst = 1'b1;
  logic              patgen_en = 1'b0;
  logic [1:0]        patgen_sel = 2'b00;
  logic              cntuspatt_en = 1'b0;
  logic [7:0]        patgen_cnt = 8'd0;
  logic              patgen_stop = 1'b0;
  logic              chkr_fifo_full = 1'b0;
  logic              axist_valid;
  logic              axist_rdy = 1'b1;
  logic [NC*DW-1:0]  patgen_dout;
  logic [DW-1:0]     patgen_exp_dout;
  logic              patgen_data_wr;
  logic              patgen_busy;
  logic              patgen_done;
  logic [15:0]       beat_cnt;

  int passed = 0;
  int total = 0;
  int done_count = 0;
  bit valid_seen = 1'b0;
  logic [DW-1:0] wr_log[$];
  logic [DW-1:0] hs_log[$];

  always #5 wr_clk = ~wr_clk;

  axi_mm_patgen_mc dut (
    .wr_clk          (wr_clk),
    .rst             (rst),
    .patgen_en       (patgen_en),
    .patgen_sel      (patgen_sel),
    .cntuspatt_en    (cntuspatt_en),
    .patgen_cnt      (patgen_cnt),
    .patgen_stop     (patgen_stop),
    .chkr_fifo_full  (chkr_fifo_full),
    .axist_valid     (axist_valid),
    .axist_rdy       (axist_rdy),
    .patgen_dout     (patgen_dout),
    .patgen_exp_dout (patgen_exp_dout),
    .patgen_data_wr  (patgen_data_wr),
    .patgen_busy     (patgen_busy),
    .patgen_done     (patgen_done),
    .beat_cnt        (beat_cnt)
  );

  task automatic check(input string tag, input logic [NC*DW-1:0] obs, input logic [NC*DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // k-th word a run of the given mode must produce, straight from the pattern definitions
  function automatic logic [DW-1:0] ref_word(input logic [1:0] sel, input int k);
    logic [DW-1:0] s;
    logic [DW-1:0] one;
    one = 40'd1;
    case (sel)
      2'b00: return 40'h33_3333_3344;
      2'b10: return 40'h44_4444_4444 + 40'(k);
      2'b11: return one << (k % DW);
      default: begin
        s = 40'hAA_5555_9001;
        repeat (k) s = {s[DW-2:0], ^(s & 40'hA0_0014_0000)};
        return s;
      end
    endcase
  endfunction

  always @(negedge wr_clk) begin
    if (!rst) begin
      if (patgen_data_wr) wr_log.push_back(patgen_exp_dout);
      else check("exp_dout_idle_zero", patgen_exp_dout, '0);
      if (chkr_fifo_full) check("chkr_full_blocks_wr", patgen_data_wr, 0);
      if (axist_valid) begin
        valid_seen = 1'b1;
        check("lanes_replicated", patgen_dout, {NC{patgen_dout[DW-1:0]}});
        if (axist_rdy) hs_log.push_back(patgen_dout[DW-1:0]);
      end else begin
        check("dout_zero_when_invalid", patgen_dout, '0);
      end
      if (patgen_done) done_count++;
    end
  end

  task automatic start_run(input logic [1:0] sel, input logic cont, input logic [7:0] cnt);
    wr_log.delete();
    hs_log.delete();
    done_count = 0;
    valid_seen = 1'b0;
    @(posedge wr_clk); #1;
    patgen_sel = sel;
    cntuspatt_en = cont;
    patgen_cnt = cnt;
    patgen_en = 1'b1;
    @(posedge wr_clk); #1;
    patgen_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_mode);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge wr_clk); #1;
      if (rand_mode) begin
        axist_rdy = ($urandom_range(0, 3) != 0);
        chkr_fifo_full = ($urandom_range(0, 3) == 0);
      end
      if (done_count > 0) break;
    end
    if (i == budget) check("done_timeout", 0, 1);
    axist_rdy = 1'b1;
    chkr_fifo_full = 1'b0;
    @(posedge wr_clk); #1;
  endtask

  task automatic check_run(input logic [1:0] sel, input int n);
    check("wr_count", wr_log.size(), n);
    check("beat_count_seen", hs_log.size(), n);
    for (int i = 0; i < n && i < wr_log.size(); i++) check("exp_word", wr_log[i], ref_word(sel, i));
    for (int i = 0; i < n && i < hs_log.size(); i++) check("lane_word", hs_log[i], ref_word(sel, i));
    check("beat_cnt", beat_cnt, n);
    check("done_pulses", done_count, 1);
    check("busy_after_run", patgen_busy, 0);
  endtask

  initial begin
    logic [1:0] rsel;
    logic [7:0] rcnt;

    // reset state
    repeat (2) @(posedge wr_clk);
    #1;
    check("rst_valid", axist_valid, 0);
    check("rst_busy", patgen_busy, 0);
    check("rst_done", patgen_done, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_data_wr", patgen_data_wr, 0);
    check("rst_exp_dout", patgen_exp_dout, 0);
    rst = 1'b0;

    // burst increment of 4
    axist_rdy = 1'b1;
    start_run(2'b10, 1'b0, 8'd4);
    wait_done(100, 1'b0);
    check_run(2'b10, 4);
    if (hs_log.size() == 4) check("incr_last", hs_log[3], 40'h44_4444_4447);

    // backpressure: fixed burst of 20 with ready low
    axist_rdy = 1'b0;
    start_run(2'b00, 1'b0, 8'd20);
    repeat (30) @(posedge wr_clk);
    #1;
    check("stall_writes", wr_log.size(), 16);
    check("stall_valid", axist_valid, 1);
    check("stall_busy", patgen_busy, 1);
    axist_rdy = 1'b1;
    wait_done(200, 1'b0);
    check_run(2'b00, 20);
    if (hs_log.size() > 0) check("fixed_word", hs_log[0], 40'h33_3333_3344);

    // PRBS with a checker-full pulse mid-run
    start_run(2'b01, 1'b0, 8'd8);
    chkr_fifo_full = 1'b1;
    repeat (5) begin
      @(posedge wr_clk); #1;
    end
    chkr_fifo_full = 1'b0;
    wait_done(200, 1'b0);
    check_run(2'b01, 8);

    // continuous walking-one, stop on the 45th write
    start_run(2'b11, 1'b1, 8'd0);
    for (int i = 0; i < 300; i++) begin
      @(posedge wr_clk); #1;
      if (patgen_data_wr && wr_log.size() == 44) begin
        patgen_stop = 1'b1;
        @(posedge wr_clk); #1;
        patgen_stop = 1'b0;
        break;
      end
    end
    wait_done(200, 1'b0);
    check_run(2'b11, 45);
    if (hs_log.size() > 40) begin
      check("walk_top_bit", hs_log[39], 40'h80_0000_0000);
      check("walk_wrap", hs_log[40], 40'h00_0000_0001);
    end

    // zero-length burst: done on the third edge after the start edge
    wr_log.delete();
    hs_log.delete();
    done_count = 0;
    valid_seen = 1'b0;
    @(posedge wr_clk); #1;
    patgen_sel = 2'b10;
    cntuspatt_en = 1'b0;
    patgen_cnt = 8'd0;
    patgen_en = 1'b1;
    @(posedge wr_clk); #1;
    patgen_en = 1'b0;
    check("zero_busy", patgen_busy, 1);
    check("zero_done_early1", patgen_done, 0);
    @(posedge wr_clk); #1;
    check("zero_done_early2", patgen_done, 0);
    @(posedge wr_clk); #1;
    check("zero_done", patgen_done, 1);
    @(posedge wr_clk); #1;
    check("zero_done_pulse", patgen_done, 0);
    check("zero_idle", patgen_busy, 0);
    check("zero_no_valid", valid_seen, 0);
    check("zero_beat_cnt", beat_cnt, 0);
    check("zero_no_writes", wr_log.size(), 0);

    // reset with 6 words buffered, then a fresh run restarts the sequence
    axist_rdy = 1'b0;
    start_run(2'b10, 1'b0, 8'd20);
    for (int i = 0; i < 50; i++) begin
      if (wr_log.size() >= 6) break;
      @(posedge wr_clk); #1;
    end
    check("pre_rst_buffered", wr_log.size(), 6);
    rst = 1'b1;
    @(posedge wr_clk); #1;
    check("mid_rst_valid", axist_valid, 0);
    check("mid_rst_busy", patgen_busy, 0);
    check("mid_rst_beat_cnt", beat_cnt, 0);
    rst = 1'b0;
    done_count = 0;
    axist_rdy = 1'b1;
    repeat (4) @(posedge wr_clk);
    #1;
    check("mid_rst_no_done", done_count, 0);
    start_run(2'b10, 1'b0, 8'd5);
    wait_done(100, 1'b0);
    check_run(2'b10, 5);

    // randomized runs with random ready and checker backpressure
    for (int r = 0; r < 5; r++) begin
      rsel = 2'($urandom_range(0, 3));
      rcnt = 8'($urandom_range(1, 40));
      start_run(rsel, 1'b0, rcnt);
      wait_done(3000, 1'b1);
      check_run(rsel, int'(rcnt));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
